// File: rtl/fruit_controller.sv
// fruit_controller: sequences fruit placement for the snake game.
// Requests a fruit from the placer at game start and after every eat,
// rejects results that land on the snake head (with a retry budget, a
// per-request watchdog and a fixed fallback cell), and owns the score
// counter and the one-cycle grow pulse.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   game_start, game_active     round restart pulse / snake-alive level
//   move_tick, head_x, head_y   head advance pulse and current head cell
//   place_req                   request pulse to the placer (combinational)
//   place_busy, place_done      placer status / result-ready pulse
//   place_x, place_y            placer result, valid with place_done
//   fruit_x, fruit_y            armed fruit cell
//   fruit_valid                 fruit present on the board
//   grow                        one-cycle pulse per eaten fruit
//   score                       saturating count of fruits eaten
//   timeout_err                 sticky watchdog-expiry flag
module fruit_controller #(
    parameter int unsigned SCORE_W        = 10,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned FALLBACK_X     = 1,
    parameter int unsigned FALLBACK_Y     = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               game_start,
    input  logic               game_active,
    input  logic               move_tick,
    input  logic [5:0]         head_x,
    input  logic [5:0]         head_y,
    output logic               place_req,
    input  logic               place_busy,
    input  logic               place_done,
    input  logic [5:0]         place_x,
    input  logic [5:0]         place_y,
    output logic [5:0]         fruit_x,
    output logic [5:0]         fruit_y,
    output logic               fruit_valid,
    output logic               grow,
    output logic [SCORE_W-1:0] score,
    output logic               timeout_err
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_ARMED
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [RTY_W-1:0]   r_retry;
    logic [5:0]         r_cand_x;
    logic [5:0]         r_cand_y;
    logic [5:0]         r_fruit_x;
    logic [5:0]         r_fruit_y;
    logic               r_fruit_valid;
    logic               r_grow;
    logic [SCORE_W-1:0] r_score;
    logic               r_timeout_err;

    logic w_retry_ok;
    logic w_timer_exp;
    logic w_head_on_cand;
    logic w_eat;

    assign w_retry_ok     = (r_retry < RTY_W'(MAX_RETRIES));
    assign w_timer_exp    = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_head_on_cand = (r_cand_x == head_x) && (r_cand_y == head_y);
    assign w_eat          = move_tick && (head_x == r_fruit_x) && (head_y == r_fruit_y);

    // Request pulse is the only combinational output.
    assign place_req   = (r_state == S_REQ) && !place_busy;

    assign fruit_x     = r_fruit_x;
    assign fruit_y     = r_fruit_y;
    assign fruit_valid = r_fruit_valid;
    assign grow        = r_grow;
    assign score       = r_score;
    assign timeout_err = r_timeout_err;

    // Placement FSM with registered outputs; restart beats game-over beats state work.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_retry       <= '0;
            r_cand_x      <= '0;
            r_cand_y      <= '0;
            r_fruit_x     <= '0;
            r_fruit_y     <= '0;
            r_fruit_valid <= 1'b0;
            r_grow        <= 1'b0;
            r_score       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_grow <= 1'b0;
            if (game_start) begin
                r_score       <= '0;
                r_fruit_valid <= 1'b0;
                r_timeout_err <= 1'b0;
                r_retry       <= '0;
                r_state       <= S_REQ;
            end else if (!game_active && (r_state != S_IDLE)) begin
                // Fruit and score are held for the game-over display.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_REQ: begin
                        if (!place_busy) begin
                            r_timer <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (place_done) begin
                            r_cand_x <= place_x;
                            r_cand_y <= place_y;
                            r_state  <= S_CHECK;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                            if (w_timer_exp) begin
                                r_timeout_err <= 1'b1;
                                if (w_retry_ok) begin
                                    r_retry <= r_retry + RTY_W'(1);
                                    r_state <= S_REQ;
                                end else begin
                                    r_fruit_x     <= 6'(FALLBACK_X);
                                    r_fruit_y     <= 6'(FALLBACK_Y);
                                    r_fruit_valid <= 1'b1;
                                    r_retry       <= '0;
                                    r_state       <= S_ARMED;
                                end
                            end
                        end
                    end
                    S_CHECK: begin
                        if (!w_head_on_cand) begin
                            r_fruit_x     <= r_cand_x;
                            r_fruit_y     <= r_cand_y;
                            r_fruit_valid <= 1'b1;
                            r_retry       <= '0;
                            r_state       <= S_ARMED;
                        end else if (w_retry_ok) begin
                            r_retry <= r_retry + RTY_W'(1);
                            r_state <= S_REQ;
                        end else begin
                            // Fallback is armed even if the head sits on it.
                            r_fruit_x     <= 6'(FALLBACK_X);
                            r_fruit_y     <= 6'(FALLBACK_Y);
                            r_fruit_valid <= 1'b1;
                            r_retry       <= '0;
                            r_state       <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (w_eat) begin
                            r_grow        <= 1'b1;
                            r_score       <= (r_score == {SCORE_W{1'b1}}) ? r_score
                                                                         : r_score + SCORE_W'(1);
                            r_fruit_valid <= 1'b0;
                            r_state       <= S_REQ;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
